// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor: receive-side safety checker for the intersection signal bus
// Ports: clk, rst_n (async, active-low), i_clr (sync clear of record and count),
//        n/s/e/w_car and n/s/e/w_ped 2-bit signal codes, i_cycle phase counter;
//        o_fault/o_fault_code/o_fault_cycle hold the first violation, o_err_cnt counts violating cycles.
module traffic_conflict_monitor #(
  parameter int P_CYCLE_MAX = 68,
  parameter int P_YEL_LEN   = 2,
  parameter int P_CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic [1:0]         n_car,
  input  logic [1:0]         s_car,
  input  logic [1:0]         e_car,
  input  logic [1:0]         w_car,
  input  logic [1:0]         n_ped,
  input  logic [1:0]         s_ped,
  input  logic [1:0]         e_ped,
  input  logic [1:0]         w_ped,
  input  logic [6:0]         i_cycle,
  output logic               o_fault,
  output logic [2:0]         o_fault_code,
  output logic [6:0]         o_fault_cycle,
  output logic [P_CNT_W-1:0] o_err_cnt
);
  localparam logic [1:0] RED = 2'b00, GRN = 2'b01, YEL = 2'b10, LFT = 2'b11;
  logic [1:0]         r_n_car_p, r_n_ped_p, r_e_car_p, r_e_ped_p;
  logic [6:0]         r_cyc_p;
  logic [2:0]         r_yel_n, r_yel_e;
  logic               r_armed, r_fault;
  logic [2:0]         r_code;
  logic [6:0]         r_fcyc;
  logic [P_CNT_W-1:0] r_cnt;
  logic [7:1]         w_v;
  logic [2:0]         w_code;
  logic [6:0]         w_cyc_exp;
  logic               w_viol;
  function automatic logic car_ok(input logic [1:0] p, input logic [1:0] c);
    return p == GRN ? (c == GRN || c == YEL) :
           p == YEL ? (c != GRN) :
           p == LFT ? (c == LFT || c == YEL) :
                      (c == RED || c == GRN);
  endfunction
  function automatic logic ped_ok(input logic [1:0] p, input logic [1:0] c);
    return p == RED ? (c == RED || c == GRN) :
           p == GRN ? (c == GRN || c == YEL) :
           p == YEL ? (c == YEL || c == RED) : 1'b0;
  endfunction
  function automatic logic [2:0] yel_next(input logic [1:0] c, input logic [2:0] r);
    return c != YEL ? 3'd0 : (r == 3'd7 ? r : r + 3'd1);
  endfunction
  function automatic logic yel_bad(input logic [1:0] p, input logic [1:0] c, input logic [2:0] r);
    return p == YEL && c != YEL && r != 3'(P_YEL_LEN);
  endfunction
  always_comb begin
    w_cyc_exp = (r_cyc_p == 7'(P_CYCLE_MAX)) ? 7'd1 : r_cyc_p + 7'd1;
    w_v[1] = n_car != RED && e_car != RED;
    w_v[2] = (n_ped != RED && n_car != RED) || (s_ped != RED && s_car != RED) ||
             (e_ped != RED && e_car != RED) || (w_ped != RED && w_car != RED);
    w_v[3] = n_car != s_car || n_ped != s_ped || e_car != w_car || e_ped != w_ped;
    w_v[4] = r_armed && (!car_ok(r_n_car_p, n_car) || !car_ok(r_e_car_p, e_car));
    w_v[5] = n_ped == 2'b11 || s_ped == 2'b11 || e_ped == 2'b11 || w_ped == 2'b11 ||
             (r_armed && (!ped_ok(r_n_ped_p, n_ped) || !ped_ok(r_e_ped_p, e_ped)));
    w_v[6] = r_armed && (yel_bad(r_n_car_p, n_car, r_yel_n) || yel_bad(r_e_car_p, e_car, r_yel_e));
    w_v[7] = i_cycle == 7'd0 || i_cycle > 7'(P_CYCLE_MAX) || (r_armed && i_cycle != w_cyc_exp);
    w_viol = |w_v;
    // lowest violated code wins the record
    w_code = w_v[1] ? 3'd1 : w_v[2] ? 3'd2 : w_v[3] ? 3'd3 : w_v[4] ? 3'd4 :
             w_v[5] ? 3'd5 : w_v[6] ? 3'd6 : w_v[7] ? 3'd7 : 3'd0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n_car_p <= '0;
      r_n_ped_p <= '0;
      r_e_car_p <= '0;
      r_e_ped_p <= '0;
      r_cyc_p   <= '0;
      r_yel_n   <= '0;
      r_yel_e   <= '0;
      r_armed   <= 1'b0;
      r_fault   <= 1'b0;
      r_code    <= '0;
      r_fcyc    <= '0;
      r_cnt     <= '0;
    end else begin
      r_n_car_p <= n_car;
      r_n_ped_p <= n_ped;
      r_e_car_p <= e_car;
      r_e_ped_p <= e_ped;
      r_cyc_p   <= i_cycle;
      r_yel_n   <= yel_next(n_car, r_yel_n);
      r_yel_e   <= yel_next(e_car, r_yel_e);
      r_armed   <= 1'b1;
      // clear takes effect first, so a same-cycle violation lands in a fresh record
      if (i_clr || !r_fault) begin
        r_fault <= w_viol;
        r_code  <= w_viol ? w_code : 3'd0;
        r_fcyc  <= w_viol ? i_cycle : 7'd0;
      end
      r_cnt <= i_clr ? {{(P_CNT_W-1){1'b0}}, w_viol} :
               (w_viol && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
    end
  end
  assign o_fault       = r_fault;
  assign o_fault_code  = r_code;
  assign o_fault_cycle = r_fcyc;
  assign o_err_cnt     = r_cnt;
endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// tb_traffic_conflict_monitor: table-driven, scoreboarded bench for traffic_conflict_monitor
module tb_traffic_conflict_monitor;
  typedef struct {
    string      nm;
    logic       rs;
    logic       clr;
    logic [1:0] nc, sc, ec, wc, np, sp, ep, wp;
    logic [6:0] cyc;
    logic       f;
    logic [2:0] code;
    logic [6:0] fc;
    logic [7:0] cnt;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_clr = 1'b0;
  logic [1:0] n_car = 2'b00, s_car = 2'b00, e_car = 2'b00, w_car = 2'b00;
  logic [1:0] n_ped = 2'b00, s_ped = 2'b00, e_ped = 2'b00, w_ped = 2'b00;
  logic [6:0] i_cycle = 7'd1;
  logic       o_fault;
  logic [2:0] o_fault_code;
  logic [6:0] o_fault_cycle;
  logic [7:0] o_err_cnt;
  int         n_cmp = 0;
  int         n_bad = 0;
  vec_t       tbl[$];
  vec_t       sb[$];
  always #5 clk = ~clk;
  traffic_conflict_monitor #(.P_CYCLE_MAX(68), .P_YEL_LEN(2), .P_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_clr(i_clr),
    .n_car(n_car), .s_car(s_car), .e_car(e_car), .w_car(w_car),
    .n_ped(n_ped), .s_ped(s_ped), .e_ped(e_ped), .w_ped(w_ped),
    .i_cycle(i_cycle), .o_fault(o_fault), .o_fault_code(o_fault_code),
    .o_fault_cycle(o_fault_cycle), .o_err_cnt(o_err_cnt)
  );
  // Legal source schedule: NS green 1-30, yellow 31-32, all red 33-34,
  // EW green 35-64, yellow 65-66, all red 67-68; peds walk while their cars are red.
  function automatic vec_t legal(input int c, input string nm);
    vec_t v;
    v.nm = nm; v.rs = 1'b0; v.clr = 1'b0; v.cyc = 7'(c);
    v.nc = c <= 30 ? 2'd1 : c <= 32 ? 2'd2 : 2'd0;
    v.ec = (c >= 35 && c <= 64) ? 2'd1 : (c >= 65 && c <= 66) ? 2'd2 : 2'd0;
    v.np = (c >= 35 && c <= 56) ? 2'd1 : (c >= 57 && c <= 62) ? 2'd2 : 2'd0;
    v.ep = c <= 22 ? 2'd1 : c <= 28 ? 2'd2 : 2'd0;
    v.sc = v.nc; v.wc = v.ec; v.sp = v.np; v.wp = v.ep;
    v.f = 1'b0; v.code = 3'd0; v.fc = 7'd0; v.cnt = 8'd0;
    return v;
  endfunction
  function automatic vec_t expect_rec(input vec_t v, input int code, input int fc, input int cnt);
    vec_t r = v;
    r.f = 1'b1; r.code = 3'(code); r.fc = 7'(fc); r.cnt = 8'(cnt);
    return r;
  endfunction
  task automatic check(input string nm, input logic f, input logic [2:0] code, input logic [6:0] fc, input logic [7:0] cnt);
    n_cmp++;
    if ({o_fault, o_fault_code, o_fault_cycle, o_err_cnt} !== {f, code, fc, cnt}) begin
      n_bad++;
      $display("FAIL %s: got f=%0d code=%0d cyc=%0d cnt=%0d, want f=%0d code=%0d cyc=%0d cnt=%0d",
               nm, o_fault, o_fault_code, o_fault_cycle, o_err_cnt, f, code, fc, cnt);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    i_clr = 1'b0;
    #1 check("rst_async", 1'b0, 3'd0, 7'd0, 8'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic step(input vec_t v);
    vec_t e;
    n_car = v.nc; s_car = v.sc; e_car = v.ec; w_car = v.wc;
    n_ped = v.np; s_ped = v.sp; e_ped = v.ep; w_ped = v.wp;
    i_cycle = v.cyc; i_clr = v.clr;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(e.nm, e.f, e.code, e.fc, e.cnt);
  endtask
  initial begin
    vec_t v;
    for (int k = 0; k < 136; k++) begin
      v = legal(k % 68 + 1, "free");
      v.rs = (k == 0);
      tbl.push_back(v);
    end
    for (int c = 1; c <= 4; c++) begin
      v = legal(c, "pre_conf");
      v.rs = (c == 1);
      tbl.push_back(v);
    end
    v = legal(5, "conflict"); v.ec = 2'd1; v.wc = 2'd1; tbl.push_back(expect_rec(v, 1, 5, 1));
    v = legal(6, "green_to_red"); tbl.push_back(expect_rec(v, 1, 5, 2));
    v = legal(7, "hold"); tbl.push_back(expect_rec(v, 1, 5, 2));
    v = legal(8, "clr"); v.clr = 1'b1; tbl.push_back(v);
    v = legal(9, "after_clr"); tbl.push_back(v);
    v = legal(10, "clr_viol"); v.clr = 1'b1; v.ec = 2'd1; v.wc = 2'd1; tbl.push_back(expect_rec(v, 1, 10, 1));
    v = legal(11, "post_clr_viol"); tbl.push_back(expect_rec(v, 1, 10, 2));
    for (int c = 1; c <= 23; c++) begin
      v = legal(c, "pre_yel");
      v.rs = (c == 1);
      if (c >= 21) begin
        v.nc = 2'd2; v.sc = 2'd2;
      end
      tbl.push_back(v);
    end
    v = legal(24, "yel_len"); v.nc = 2'd3; v.sc = 2'd3; tbl.push_back(expect_rec(v, 6, 24, 1));
    for (int c = 1; c <= 10; c++) begin
      v = legal(c, "pre_skip");
      v.rs = (c == 1);
      tbl.push_back(v);
    end
    v = legal(12, "skip"); tbl.push_back(expect_rec(v, 7, 12, 1));
    v = legal(13, "cyc69"); v.cyc = 7'd69; tbl.push_back(expect_rec(v, 7, 12, 2));
    v = legal(33, "ped11"); v.rs = 1'b1; v.np = 2'd3; v.sp = 2'd3; tbl.push_back(expect_rec(v, 5, 33, 1));
    v = legal(1, "ped_pre"); v.rs = 1'b1; tbl.push_back(v);
    v = legal(2, "ped_g2r"); v.ep = 2'd0; v.wp = 2'd0; tbl.push_back(expect_rec(v, 5, 2, 1));
    v = legal(40, "rel40"); v.rs = 1'b1; tbl.push_back(v);
    v = legal(41, "run41"); tbl.push_back(v);
    for (int k = 1; k <= 260; k++) begin
      v = legal(5, "sat");
      v.rs = (k == 1); v.ec = 2'd1; v.wc = 2'd1;
      tbl.push_back(expect_rec(v, 1, 5, k > 255 ? 255 : k));
    end
    foreach (tbl[i]) begin
      if (tbl[i].rs) do_reset();
      step(tbl[i]);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("rst_midclk", 1'b0, 3'd0, 7'd0, 8'd0);
    @(posedge clk);
    #1 check("rst_held", 1'b0, 3'd0, 7'd0, 8'd0);
    rst_n = 1'b1;
    step(legal(40, "rejoin40"));
    step(legal(41, "rejoin41"));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/traffic_conflict_monitor.md
# traffic_conflict_monitor

Receive-side safety checker for the intersection signal bus driven by `top`. It samples the eight 2-bit car/ped signal codes and the shared phase counter every clock. It detects conflicting greens, illegal signal sequences, wrong yellow dwell and phase-counter corruption. On the first violation it latches a fault record and keeps a saturating count of violating cycles. A supervisor reads the record and clears it with `i_clr`.

## Interface
- `P_CYCLE_MAX`, 68: last phase-counter value; the counter wraps to 1 after it.
- `P_YEL_LEN`, 2: required length of every car YELLOW run, in cycles.
- `P_CNT_W`, 8: width of the error counter.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_clr` in 1: synchronous clear of the fault record and error count.
- `n_car`, `s_car`, `e_car`, `w_car` in 2 each: car codes. RED=00, GREEN=01, YELLOW=10, LEFT=11.
- `n_ped`, `s_ped`, `e_ped`, `w_ped` in 2 each: ped codes. RED=00, GREEN=01, BLINK=10; 11 is illegal.
- `i_cycle` in 7: phase counter, legal range 1..P_CYCLE_MAX.
- `o_fault` out 1: latched fault flag.
- `o_fault_code` out 3: code of the first violation.
- `o_fault_cycle` out 7: `i_cycle` value sampled at the first violation.
- `o_err_cnt` out P_CNT_W: number of cycles with at least one violation, saturating.

## Operation
- Sampling: inputs are sampled on every rising edge, and all checks evaluate the sampled values.
- History registers:
  - previous car and ped code for the NS group (n) and EW group (e);
  - previous `i_cycle`;
  - yellow run length per group;
  - `r_armed`.
- Static checks, active from the first sample after reset:
  - Code 1: NS car non-RED while EW car non-RED, using `n_car` vs `e_car`.
  - Code 2: on any approach, ped non-RED while that approach's car is non-RED.
  - Code 3: pair mismatch, i.e. `n_car`≠`s_car`, `n_ped`≠`s_ped`, `e_car`≠`w_car` or `e_ped`≠`w_ped`.
  - Code 5 (static part): any ped code equal to 11.
  - Code 7 (static part): `i_cycle`==0 or `i_cycle`>P_CYCLE_MAX.
- History checks, active only when `r_armed`=1:
  - Code 4: illegal car transition in either group. Legal transitions are GREEN→GREEN/YELLOW, YELLOW→YELLOW/LEFT/RED, LEFT→LEFT/YELLOW and RED→RED/GREEN.
  - Code 5: illegal ped transition. Legal transitions are RED→RED/GREEN, GREEN→GREEN/BLINK and BLINK→BLINK/RED.
  - Code 6: a group leaves YELLOW with a yellow run length ≠ P_YEL_LEN.
  - Code 7: `i_cycle` ≠ the expected value. The expected value is prev+1, or 1 when prev==P_CYCLE_MAX.
- Yellow run counter:
  - It counts consecutive YELLOW samples per group and saturates at 7.
  - It resets to 0 on any non-YELLOW sample.
- `r_armed` sets after the first post-reset sample. `i_clr` does not clear it.
- Simultaneous violations: the cycle counts once, and the record takes the lowest code number.
- Fault record:
  - It is written only while `o_fault`=0.
  - Once `o_fault`=1, `o_fault_code` and `o_fault_cycle` hold until `i_clr` or reset.
- `o_err_cnt` increments by 1 per violating cycle and saturates at 2^P_CNT_W−1.
- `i_clr`:
  - It zeroes `o_fault`, `o_fault_code`, `o_fault_cycle` and `o_err_cnt`.
  - If a violation occurs in the same cycle, the clear applies first and the violation is then recorded. The result is `o_fault`=1, the new code and cycle, and `o_err_cnt`=1.

## Timing
- Reset:
  - All outputs go to 0 asynchronously on `rst_n` low.
  - History registers go to 0 and `r_armed` goes to 0.
- Latency: a violation present in the inputs before edge k appears on all outputs immediately after edge k, i.e. 1 cycle.
- All outputs are registered; there are no combinational input→output paths.
- Reset mid-operation: after `rst_n` rises, the first sample runs only static checks, so a discontinuity in `i_cycle` or in a sequence is not flagged.
- Monitor and source reset together: the source restarts at cycle 1, the monitor re-arms on that sample, and no fault is raised.

## Test plan
- Fault-free run: drive from `top` with a common `rst_n` for 136 cycles (two periods) → `o_fault`=0 and `o_err_cnt`=0 throughout.
- Conflicting green: force `e_car`=`w_car`=GREEN during cycle 5 only (n is GREEN) → after that edge `o_fault`=1, code=1, `o_fault_cycle`=5 and cnt=1. The next edge flags GREEN→RED, so cnt=2 while the code stays 1.
- Yellow dwell: hold `n_car`=`s_car`=YELLOW for cycles 21–23, then LEFT at cycle 24 → after the cycle-24 sample, code=6, `o_fault_cycle`=24 and cnt=1.
- Counter skip: drive `i_cycle` 10 then 12 with legal signal codes → code=7, `o_fault_cycle`=12 and cnt=1. Also drive `i_cycle`=69 → another count, with the code still 7.
- Ped errors: drive `n_ped`=`s_ped`=11 while `n_car`=RED → code=5. Separately, drive `e_ped` GREEN→RED directly (with `w_ped` matching) → code=5.
- Clear and reset:
  - After a fault, pulse `i_clr` → all outputs are 0 on the next cycle.
  - Pulse `i_clr` together with a code-1 violation → `o_fault`=1, code=1, cnt=1.
  - Drop `rst_n` asynchronously mid-clock → outputs are 0 before the next edge.
  - Release `rst_n` with `i_cycle`=40 → no code-7 fault is raised.
